// File: rtl/clock_period_meter.sv
// Measures the period of a slow external clock (meas_in) in clk cycles and flags its loss.
// Define PERIOD_AVG_EN to report the mean of 2**AVG_LOG2 consecutive periods instead of every period.
module clock_period_meter #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned MIN_FREQ = 1_000,
    parameter int unsigned AVG_LOG2 = 2,
    localparam int unsigned TIMEOUT  = CLK_FREQ / MIN_FREQ,
    localparam int unsigned PERIOD_W = $clog2(TIMEOUT + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                meas_in,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                locked,
    output logic                timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic [PERIOD_W-1:0] TIMEOUT_C = PERIOD_W'(TIMEOUT);

    // Reject configurations that cannot measure anything or overflow the averaging shift.
    if (MIN_FREQ == 0 || MIN_FREQ > CLK_FREQ / 2 || AVG_LOG2 > 30) begin : g_param_check
        $error("clock_period_meter: invalid CLK_FREQ/MIN_FREQ/AVG_LOG2");
    end

    logic                sync1;
    logic                sync2;
    logic                prev;
    logic                rise_c;
    logic [PERIOD_W-1:0] cnt;

    state_t              state;
    state_t              state_nxt;
    logic [PERIOD_W-1:0] period_nxt;
    logic                valid_nxt;
    logic                locked_nxt;
    logic                timeout_nxt;

`ifdef PERIOD_AVG_EN
    localparam int unsigned ACC_W = PERIOD_W + AVG_LOG2;
    localparam int unsigned SMP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [ACC_W-1:0] acc_sum_c;
    logic [SMP_W-1:0] smp;
    logic [SMP_W-1:0] smp_nxt;

    assign acc_sum_c = acc + ACC_W'(cnt);
`endif

    // Two-flop synchroniser plus edge-history flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= meas_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise_c = sync2 & ~prev;

    // Cycles since the last rising edge; restarts at 1 so a P-cycle period reads P on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (rise_c) begin
            cnt <= PERIOD_W'(1);
        end else if (cnt != TIMEOUT_C) begin
            cnt <= cnt + PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
`ifdef PERIOD_AVG_EN
            acc          <= '0;
            smp          <= '0;
`endif
        end else begin
            state        <= state_nxt;
            period       <= period_nxt;
            period_valid <= valid_nxt;
            locked       <= locked_nxt;
            timeout      <= timeout_nxt;
`ifdef PERIOD_AVG_EN
            acc          <= acc_nxt;
            smp          <= smp_nxt;
`endif
        end
    end

    // Next state and outputs; a rise takes priority over a coincident timeout.
    always_comb begin
        state_nxt   = state;
        period_nxt  = period;
        valid_nxt   = 1'b0;
        locked_nxt  = locked;
        timeout_nxt = 1'b0;
`ifdef PERIOD_AVG_EN
        acc_nxt     = acc;
        smp_nxt     = smp;
`endif
        if (!en) begin
            state_nxt  = IDLE;
            locked_nxt = 1'b0;
`ifdef PERIOD_AVG_EN
            acc_nxt    = '0;
            smp_nxt    = '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (rise_c) begin
                        state_nxt = ARMED;
`ifdef PERIOD_AVG_EN
                        acc_nxt   = '0;
                        smp_nxt   = '0;
`endif
                    end
                end
                ARMED: begin
                    if (rise_c) begin
`ifdef PERIOD_AVG_EN
                        if (smp == SMP_LAST) begin
                            period_nxt = PERIOD_W'(acc_sum_c >> AVG_LOG2);
                            valid_nxt  = 1'b1;
                            locked_nxt = 1'b1;
                            acc_nxt    = '0;
                            smp_nxt    = '0;
                        end else begin
                            acc_nxt = acc_sum_c;
                            smp_nxt = smp + SMP_W'(1);
                        end
`else
                        period_nxt = cnt;
                        valid_nxt  = 1'b1;
                        locked_nxt = 1'b1;
`endif
                    end else if (cnt == TIMEOUT_C) begin
                        state_nxt   = IDLE;
                        timeout_nxt = 1'b1;
                        locked_nxt  = 1'b0;
`ifdef PERIOD_AVG_EN
                        acc_nxt     = '0;
                        smp_nxt     = '0;
`endif
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_period_meter.sv
// Randomised scoreboard bench for clock_period_meter; expectations come from rise timestamps.
module tb_clock_period_meter;

    localparam int unsigned CLK_FREQ = 100_000;
    localparam int unsigned MIN_FREQ = 50;
    localparam int unsigned AVG_LOG2 = 2;
    localparam int unsigned TIMEOUT  = CLK_FREQ / MIN_FREQ;
    localparam int unsigned PERIOD_W = $clog2(TIMEOUT + 1);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                en = 1'b0;
    logic                meas_in = 1'b0;
    logic [PERIOD_W-1:0] period;
    logic                period_valid;
    logic                locked;
    logic                timeout;

    clock_period_meter #(
        .CLK_FREQ(CLK_FREQ),
        .MIN_FREQ(MIN_FREQ),
        .AVG_LOG2(AVG_LOG2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .meas_in     (meas_in),
        .period      (period),
        .period_valid(period_valid),
        .locked      (locked),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_to;
        int unsigned per;
        int unsigned at;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned rise_q[$];
    int unsigned edge_n = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned exp_period = 0;
    bit          exp_locked = 1'b0;
    bit          m_armed = 1'b0;
    int unsigned last_rise = 0;
`ifdef PERIOD_AVG_EN
    int unsigned acc_sum = 0;
    int unsigned acc_n = 0;
`endif

    task automatic chk(input bit ok, input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_n);
        end
    endtask

    task automatic push_exp(input bit is_to, input int unsigned per);
        exp_t e;
        e.is_to = is_to;
        e.per   = per;
        e.at    = edge_n;
        exp_q.push_back(e);
    endtask

    task automatic model_clear_avg();
`ifdef PERIOD_AVG_EN
        acc_sum = 0;
        acc_n   = 0;
`endif
    endtask

    task automatic model_report(input int unsigned p);
`ifdef PERIOD_AVG_EN
        acc_sum += p;
        acc_n++;
        if (acc_n == (1 << AVG_LOG2)) begin
            push_exp(1'b0, acc_sum >> AVG_LOG2);
            exp_period = acc_sum >> AVG_LOG2;
            exp_locked = 1'b1;
            model_clear_avg();
        end
`else
        push_exp(1'b0, p);
        exp_period = p;
        exp_locked = 1'b1;
`endif
    endtask

    // Reference: a rise is seen 3 edges after meas_in is driven high; periods are timestamp differences.
    task automatic model_loop();
        bit is_rise;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_armed    = 1'b0;
                exp_period = 0;
                exp_locked = 1'b0;
                rise_q.delete();
                exp_q.delete();
                model_clear_avg();
            end else begin
                edge_n++;
                is_rise = 1'b0;
                if (rise_q.size() != 0 && rise_q[0] == edge_n) begin
                    is_rise = 1'b1;
                    void'(rise_q.pop_front());
                end
                if (!en) begin
                    m_armed    = 1'b0;
                    exp_locked = 1'b0;
                    model_clear_avg();
                end else if (!m_armed) begin
                    if (is_rise) begin
                        m_armed   = 1'b1;
                        last_rise = edge_n;
                        model_clear_avg();
                    end
                end else if (is_rise) begin
                    model_report(edge_n - last_rise);
                    last_rise = edge_n;
                end else if (edge_n - last_rise >= TIMEOUT) begin
                    push_exp(1'b1, 0);
                    m_armed    = 1'b0;
                    exp_locked = 1'b0;
                    model_clear_avg();
                end
            end
        end
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (period_valid || timeout) begin
                    chk(!(period_valid && timeout), "valid_and_timeout", 1, 0);
                    chk(exp_q.size() != 0, "pulse_expected", 32'(exp_q.size()), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk(e.at == edge_n, "pulse_edge", edge_n, e.at);
                        chk(timeout == e.is_to, "pulse_kind_timeout", 32'(timeout), 32'(e.is_to));
                        if (!e.is_to)
                            chk(period == PERIOD_W'(e.per), "period", 32'(period), e.per);
                        chk(locked == exp_locked, "locked_at_pulse", 32'(locked), 32'(exp_locked));
                    end
                end
                if (edge_n % 32 == 0) begin
                    chk(period == PERIOD_W'(exp_period), "period_hold", 32'(period), exp_period);
                    chk(locked == exp_locked, "locked", 32'(locked), 32'(exp_locked));
                end
            end
        end
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_meas(input bit v);
        if (v && !meas_in)
            rise_q.push_back(edge_n + 3);
        meas_in = v;
    endtask

    task automatic square(input int unsigned p, input int unsigned n);
        for (int i = 0; i < int'(n); i++) begin
            int unsigned h;
            h = $urandom_range(p - 1, 1);
            set_meas(1'b1);
            cyc(h);
            set_meas(1'b0);
            cyc(p - h);
        end
    endtask

    task automatic drain(input int unsigned n);
        cyc(n);
        #1;
        chk(exp_q.size() == 0, "pending_expected", 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    initial begin
        fork
            model_loop();
            monitor_loop();
        join_none

        cyc(3);
        chk(period == '0, "reset_period", 32'(period), 0);
        chk(period_valid == 1'b0, "reset_valid", 32'(period_valid), 0);
        chk(locked == 1'b0, "reset_locked", 32'(locked), 0);
        chk(timeout == 1'b0, "reset_timeout", 32'(timeout), 0);
        rst_n = 1'b1;
        en    = 1'b1;
        cyc(5);

        // Steady 1000-cycle wave, then loss of signal.
        square(1000, 6);
        drain(TIMEOUT + 20);
        chk(period == PERIOD_W'(1000), "period_after_timeout", 32'(period), 1000);
        chk(locked == 1'b0, "locked_after_timeout", 32'(locked), 0);

        // Minimum period.
        square(2, 30);
        drain(TIMEOUT + 20);

        // Enable dropped mid-measurement and re-raised.
        square(400, 3);
        set_meas(1'b1);
        cyc(100);
        en = 1'b0;
        cyc(100);
        set_meas(1'b0);
        cyc(200);
        square(400, 2);
        en = 1'b1;
        square(400, 4);
        drain(TIMEOUT + 20);

        // Period exactly TIMEOUT is measured; TIMEOUT+1 times out and rearms.
        set_meas(1'b1); cyc(5); set_meas(1'b0); cyc(TIMEOUT - 5);
        set_meas(1'b1); cyc(5); set_meas(1'b0); cyc(TIMEOUT + 1 - 5);
        set_meas(1'b1); cyc(5); set_meas(1'b0); cyc(495);
        square(500, 5);
        drain(TIMEOUT + 20);

        // Random periods with occasional enable gaps.
        for (int i = 0; i < 40; i++) begin
            square($urandom_range(600, 2), $urandom_range(3, 1));
            if ($urandom_range(7, 0) == 0) begin
                en = 1'b0;
                cyc($urandom_range(50, 1));
                en = 1'b1;
            end
        end
        drain(TIMEOUT + 20);

        // Asynchronous reset while locked.
        square(300, 6);
        cyc(10);
        chk(locked == 1'b1, "locked_before_reset", 32'(locked), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk(period == '0, "async_reset_period", 32'(period), 0);
        chk(period_valid == 1'b0, "async_reset_valid", 32'(period_valid), 0);
        chk(locked == 1'b0, "async_reset_locked", 32'(locked), 0);
        chk(timeout == 1'b0, "async_reset_timeout", 32'(timeout), 0);
        cyc(4);
        rst_n = 1'b1;
        cyc(3);
        square(250, 6);
        drain(TIMEOUT + 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
